// File: rtl/vx_perf_pkg.sv
// Shared definitions for the performance-counter collectors.
// Provides the counter width (overridable via the PERF_CTR_BITS macro),
// the counter type and the width of the outstanding-read tracker.

`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

package vx_perf_pkg;

    localparam int unsigned PERF_CTR_BITS     = `PERF_CTR_BITS;
    localparam int unsigned PERF_PENDING_BITS = 16;

    typedef logic [`PERF_CTR_BITS-1:0] perf_ctr_t;

endpackage

// File: rtl/vx_perf_pop_acc.sv
// Popcount accumulator: every cycle adds the number of set bits of an
// N-bit event vector to a W-bit wrapping counter.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset, clears the counter
//   clear_i  synchronous clear; wins over the same-cycle increment
//   ev_i     N event bits, each one counts as +1 this cycle
//   acc_o    registered W-bit accumulator value

module vx_perf_pop_acc #(
    parameter int unsigned N = 1,
    parameter int unsigned W = 44
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic [N-1:0] ev_i,
    output logic [W-1:0] acc_o
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  acc_d, acc_q;

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt = cnt + CW'(ev_i[i]);
        end
    end

    always_comb begin
        acc_d = acc_q + W'(cnt);
        if (clear_i) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/vx_perf_mem_collector.sv
// Memory-side performance counter collector.
// Watches NUM_PORTS valid/ready memory ports and accumulates read, write and
// duplicate-request counts, plus a latency sum (outstanding reads summed per
// cycle; average latency = mem_latency / mem_reads).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   perf_clear        synchronous clear of the four counters (not the tracker)
//   mem_req_valid/ready/rw   request handshake per port, rw=1 is a write
//   mem_rsp_valid/ready      read response handshake per port
//   dup_req           per-port pulse for a duplicate request merged upstream
//   mem_reads, mem_writes, mem_latency, dup_reqs   registered counters
//   pending_reads     current outstanding-read count (debug)

module vx_perf_mem_collector
    import vx_perf_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 1,
    parameter int unsigned CTR_BITS     = PERF_CTR_BITS,
    parameter int unsigned PENDING_BITS = PERF_PENDING_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    perf_clear,
    input  logic [NUM_PORTS-1:0]    mem_req_valid,
    input  logic [NUM_PORTS-1:0]    mem_req_ready,
    input  logic [NUM_PORTS-1:0]    mem_req_rw,
    input  logic [NUM_PORTS-1:0]    mem_rsp_valid,
    input  logic [NUM_PORTS-1:0]    mem_rsp_ready,
    input  logic [NUM_PORTS-1:0]    dup_req,
    output logic [CTR_BITS-1:0]     mem_reads,
    output logic [CTR_BITS-1:0]     mem_writes,
    output logic [CTR_BITS-1:0]     mem_latency,
    output logic [CTR_BITS-1:0]     dup_reqs,
    output logic [PENDING_BITS-1:0] pending_reads
);

    localparam int unsigned CW = $clog2(NUM_PORTS + 1);
    // Two guard bits: one for the carry of the add, one so the
    // compare against the response count never wraps.
    localparam int unsigned SW = PENDING_BITS + 2;
    localparam logic [SW-1:0] PEND_MAX = {2'b00, {PENDING_BITS{1'b1}}};

    logic [NUM_PORTS-1:0]    req_fire, rd_fire, wr_fire, rsp_fire;
    logic [CW-1:0]           rd_cnt, rsp_cnt;
    logic [SW-1:0]           pend_sum, pend_diff;
    logic                    underflow, overflow;
    logic [PENDING_BITS-1:0] pending_d, pending_q;
    logic [CTR_BITS-1:0]     lat_d, lat_q;

    assign req_fire = mem_req_valid & mem_req_ready;
    assign rd_fire  = req_fire & ~mem_req_rw;
    assign wr_fire  = req_fire & mem_req_rw;
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

    vx_perf_pop_acc #(.N(NUM_PORTS), .W(CTR_BITS)) u_reads (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (perf_clear),
        .ev_i    (rd_fire),
        .acc_o   (mem_reads)
    );

    vx_perf_pop_acc #(.N(NUM_PORTS), .W(CTR_BITS)) u_writes (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (perf_clear),
        .ev_i    (wr_fire),
        .acc_o   (mem_writes)
    );

    vx_perf_pop_acc #(.N(NUM_PORTS), .W(CTR_BITS)) u_dups (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (perf_clear),
        .ev_i    (dup_req),
        .acc_o   (dup_reqs)
    );

    always_comb begin
        rd_cnt  = '0;
        rsp_cnt = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            rd_cnt  = rd_cnt + CW'(rd_fire[i]);
            rsp_cnt = rsp_cnt + CW'(rsp_fire[i]);
        end
    end

    // Reads are added before responses are removed, so a response that
    // fires together with its own request never looks like an underflow.
    always_comb begin
        pend_sum  = SW'(pending_q) + SW'(rd_cnt);
        pend_diff = pend_sum - SW'(rsp_cnt);
        underflow = (pend_sum < SW'(rsp_cnt));
        overflow  = !underflow && (pend_diff > PEND_MAX);
        pending_d = pend_diff[PENDING_BITS-1:0];
        if (underflow) begin
            pending_d = '0;
        end else if (overflow) begin
            pending_d = '1;
        end
    end

    // Latency uses the tracker value from before this cycle's update.
    always_comb begin
        lat_d = lat_q + CTR_BITS'(pending_q);
        if (perf_clear) begin
            lat_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            lat_q     <= '0;
        end else begin
            pending_q <= pending_d;
            lat_q     <= lat_d;
        end
    end

    assign mem_latency   = lat_q;
    assign pending_reads = pending_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!underflow)
                else $warning("vx_perf_mem_collector: read response with no outstanding read");
            assert (!overflow)
                else $warning("vx_perf_mem_collector: outstanding-read tracker saturated");
        end
    end
`endif

endmodule
